// File: rtl/connect4_pkg.sv
// Shared Connect-4 types: board geometry, cell encoding, writer FSM states.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package connect4_pkg;

    localparam int ROWS = 6;
    localparam int COLS = 7;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        P1    = 2'b01,
        P2    = 2'b10
    } cell_t;

    // Row 0 is the top of the board, row ROWS-1 the bottom.
    typedef cell_t [ROWS-1:0][COLS-1:0] board_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FALL   = 2'd1,
        COMMIT = 2'd2
    } bw_state_t;

    // Reads one cell. Coordinates off the board read as EMPTY, so callers
    // can probe "the cell below" or an unchecked column without range
    // errors.
    function automatic cell_t cell_at(input board_t b,
                                      input logic [2:0] row,
                                      input logic [2:0] col);
        cell_at = EMPTY;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (row == r[2:0] && col == c[2:0]) begin
                    cell_at = b[r][c];
                end
            end
        end
    endfunction

endpackage

// File: rtl/board_writer_if.sv
// Move-request handshake between a move source and the board writer.
// Latency: n/a (wires only).
// Backpressure: move_ready from the writer; a request transfers when
// move_valid && move_ready on a clock edge.
//   move_valid : request present
//   move_ready : writer can take a request
//   column     : target column 0..6
//   player     : 01 = P1, 10 = P2
interface board_writer_if;
    logic       move_valid;
    logic       move_ready;
    logic [2:0] column;
    logic [1:0] player;

    modport master (output move_valid, output column, output player,
                    input  move_ready);
    modport slave  (input  move_valid, input  column, input  player,
                    output move_ready);
endinterface

// File: rtl/drop_timer.sv
// Dwell counter for the falling piece: expire marks the last cycle of a row.
// Latency: expire is high DROP_TICKS cycles after restart is released.
// Backpressure: none; restart takes priority over counting.
//   clk, rst : clock, async active-high reset
//   restart  : force the count to zero on the next edge
//   expire   : count has reached DROP_TICKS-1
module drop_timer #(
    parameter int DROP_TICKS = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic expire
);
    localparam int             W    = $clog2(DROP_TICKS + 1);
    localparam logic [W-1:0]   LAST = W'(DROP_TICKS - 1);

    logic [W-1:0] tick;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick <= '0;
        end else if (restart) begin
            tick <= '0;
        end else begin
            tick <= tick + W'(1);
        end
    end

    assign expire = (tick == LAST);

endmodule

// File: rtl/board_writer.sv
// Owns the Connect-4 board; animates a piece falling down a column and commits it.
// Latency: move accepted at E0, landing on row r, is visible after E0+(r+1)*DROP_TICKS+1.
// Backpressure: move_ready only in IDLE; requests while busy are dropped, not queued.
//   clk, rst        : clock, async active-high reset
//   clear           : synchronous board wipe, aborts any fall
//   mv              : move handshake (valid/ready, column, player)
//   board           : board state, read directly by display and win logic
//   falling_*       : animation position/owner, falling_active while in FALL
//   done, done_row  : commit pulse and the row written (held)
//   reject          : pulse for an illegal request
//   board_full      : every top-row cell occupied
module board_writer
    import connect4_pkg::*;
#(
    parameter int DROP_TICKS = 12_500_000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    board_writer_if.slave  mv,
    output board_t         board,
    output logic           falling_active,
    output logic [2:0]     falling_row,
    output logic [2:0]     falling_col,
    output logic [1:0]     falling_player,
    output logic           done,
    output logic [2:0]     done_row,
    output logic           reject,
    output logic           board_full
);

    bw_state_t state, next_state;

    logic move_ready;
    logic accept;
    logic illegal;
    logic land;
    logic expire;
    logic timer_restart;

    // The timer only runs in FALL; it is held at zero elsewhere so the first
    // row gets a full dwell, and wraps to zero at each row boundary.
    assign timer_restart = (state != FALL) || expire;

    drop_timer #(
        .DROP_TICKS (DROP_TICKS)
    ) u_drop_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (timer_restart),
        .expire  (expire)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        if (clear) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept && !illegal) next_state = FALL;
                FALL:    if (expire && land)     next_state = COMMIT;
                COMMIT:  next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Combinational outputs and decode
    always_comb begin
        move_ready = (state == IDLE);
        accept     = mv.move_valid && move_ready;
        illegal    = (mv.column > 3'd6)
                  || ((mv.player != P1) && (mv.player != P2))
                  || (cell_at(board, 3'd0, mv.column) != EMPTY);
        // The piece stops on the bottom row or on top of an occupied cell.
        land       = (falling_row == 3'd5)
                  || (cell_at(board, falling_row + 3'd1, falling_col) != EMPTY);
    end

    assign mv.move_ready = move_ready;

    always_comb begin
        board_full = 1'b1;
        for (int c = 0; c < COLS; c++) begin
            if (board[0][c] == EMPTY) board_full = 1'b0;
        end
    end

    // Registered datapath: board, animation position and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            board          <= '0;
            falling_active <= 1'b0;
            falling_row    <= '0;
            falling_col    <= '0;
            falling_player <= '0;
            done           <= 1'b0;
            done_row       <= '0;
            reject         <= 1'b0;
        end else begin
            done           <= 1'b0;
            reject         <= 1'b0;
            falling_active <= (next_state == FALL);
            if (clear) begin
                board       <= '0;
                falling_row <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            if (illegal) begin
                                reject <= 1'b1;
                            end else begin
                                falling_row    <= '0;
                                falling_col    <= mv.column;
                                falling_player <= mv.player;
                            end
                        end
                    end
                    FALL: begin
                        if (expire && !land) falling_row <= falling_row + 3'd1;
                    end
                    COMMIT: begin
                        for (int r = 0; r < ROWS; r++) begin
                            for (int c = 0; c < COLS; c++) begin
                                if (falling_row == r[2:0] && falling_col == c[2:0]) begin
                                    board[r][c] <= cell_t'(falling_player);
                                end
                            end
                        end
                        done_row <= falling_row;
                        done     <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
